sum_uart_sequencer: RTL and testbench



---
 rtl/sum_uart_pkg.sv | 31 +++
 rtl/sum_uart_sequencer_button_edge_sync.sv | 27 ++
 rtl/sum_uart_sequencer.sv | 148 ++++++++++++++
 tb/tb_sum_uart_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum-latch UART sequencer: FSM states,
// ASCII byte values, frame sizing and the hex-to-ASCII helper.
package sum_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        DONE
    } seq_state_t;

    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_PLUS       = 8'h2B;
    localparam logic [7:0] ASCII_EQ         = 8'h3D;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

    // Longest frame: four echo bytes, two digits, CR and LF.
    localparam int MAX_FRAME_LEN = 8;
    localparam int IDX_W         = $clog2(MAX_FRAME_LEN);

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_ZERO + {4'd0, nib};
        else
            return ASCII_ALPHA_BASE + {4'd0, nib};
    endfunction

endpackage

// File: rtl/sum_uart_sequencer_button_edge_sync.sv
// Button synchronizer (preset high = released) followed by a registered
// falling-edge detector; the pulse appears SYNC_STAGES+1 cycles after the pin falls.
module button_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   level_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0    <= '1;
            level_p1   <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            sync_p0    <= {sync_p0[SYNC_STAGES-2:0], btn_n};
            level_p1   <= sync_p0[SYNC_STAGES-1];
            fall_pulse <= level_p1 & ~sync_p0[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/sum_uart_sequencer.sv
// Captures operands A/B from button strobes, adds them and sequences the ASCII
// frame into a UART TX. Optional macro SUM_ECHO_OPERANDS_EN prepends "A+B=" in hex.
module sum_uart_sequencer
    import sum_uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TERM_CRLF   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       save_a_n,
    input  logic       save_b_n,
    input  logic [3:0] data_input,
    input  logic       uart_tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [4:0] sum_out,
    output logic       a_valid,
    output logic       b_valid,
    output logic       seq_busy
);

`ifdef SUM_ECHO_OPERANDS_EN
    localparam int ECHO_LEN = 4;
`else
    localparam int ECHO_LEN = 0;
`endif
    localparam int TERM_LEN  = (TERM_CRLF != 0) ? 2 : 1;
    localparam int FRAME_LEN = ECHO_LEN + 2 + TERM_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    seq_state_t       state;
    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic [IDX_W-1:0] idx;
    logic             cap_a;
    logic             cap_b;
    logic [3:0]       a_next;
    logic [3:0]       b_next;
    logic [1:0]       sum_tens;
    logic [3:0]       sum_ones;
    logic [IDX_W-1:0] tail_idx;
    logic [7:0]       cur_byte;

    button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (save_a_n),
        .fall_pulse (cap_a)
    );

    button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (save_b_n),
        .fall_pulse (cap_b)
    );

    // A capture landing in the same cycle the sum is formed must be reflected in it.
    assign a_next = cap_a ? data_input : op_a;
    assign b_next = cap_b ? data_input : op_b;

    always_comb begin
        sum_tens = (sum_out >= 5'd30) ? 2'd3 :
                   (sum_out >= 5'd20) ? 2'd2 :
                   (sum_out >= 5'd10) ? 2'd1 : 2'd0;
        sum_ones = 4'(sum_out - 5'(sum_tens) * 5'd10);
    end

    always_comb begin
        tail_idx = idx - IDX_W'(ECHO_LEN);
        case (tail_idx)
            IDX_W'(0): cur_byte = ASCII_ZERO + {6'd0, sum_tens};
            IDX_W'(1): cur_byte = ASCII_ZERO + {4'd0, sum_ones};
            IDX_W'(2): cur_byte = (TERM_CRLF != 0) ? ASCII_CR : ASCII_LF;
            default:   cur_byte = ASCII_LF;
        endcase
`ifdef SUM_ECHO_OPERANDS_EN
        case (idx)
            IDX_W'(0): cur_byte = hex_to_ascii(op_a);
            IDX_W'(1): cur_byte = ASCII_PLUS;
            IDX_W'(2): cur_byte = hex_to_ascii(op_b);
            IDX_W'(3): cur_byte = ASCII_EQ;
            default:   ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            sum_out  <= '0;
            idx      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            seq_busy <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cap_a) begin
                        op_a    <= data_input;
                        a_valid <= 1'b1;
                    end
                    if (cap_b) begin
                        op_b    <= data_input;
                        b_valid <= 1'b1;
                    end
                    if (a_valid && b_valid) begin
                        sum_out  <= 5'(a_next) + 5'(b_next);
                        seq_busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= cur_byte;
                    if (!uart_tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (uart_tx_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        idx   <= idx + 1'b1;
                        state <= (idx == LAST_IDX) ? DONE : LOAD;
                    end
                end
                DONE: begin
                    a_valid  <= 1'b0;
                    b_valid  <= 1'b0;
                    idx      <= '0;
                    seq_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// Directed plus randomized bench for sum_uart_sequencer with a behavioural UART
// responder and a frame reference model built from the decimal/hex formatting rules.
module tb_sum_uart_sequencer;

`ifdef SUM_ECHO_OPERANDS_EN
    localparam int TB_CRLF = 0;
`else
    localparam int TB_CRLF = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic       save_a_n;
    logic       save_b_n;
    logic [3:0] data_input;
    logic       uart_tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] sum_out;
    logic       a_valid;
    logic       b_valid;
    logic       seq_busy;

    logic       m_busy;
    logic       hold_busy;
    int         busy_cnt;
    int         busy_lo;
    int         busy_hi;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         start_cnt;
    int         stab_err;
    logic       act;
    logic       seen_hi;
    logic [7:0] act_byte;

    int checks;
    int errors;

    sum_uart_sequencer #(.SYNC_STAGES(2), .TERM_CRLF(TB_CRLF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .save_a_n     (save_a_n),
        .save_b_n     (save_b_n),
        .data_input   (data_input),
        .uart_tx_busy (uart_tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .sum_out      (sum_out),
        .a_valid      (a_valid),
        .b_valid      (b_valid),
        .seq_busy     (seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART transmitter model: busy rises the cycle after a start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy   <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            m_busy   <= 1'b1;
            busy_cnt <= int'($urandom_range(busy_hi, busy_lo));
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            m_busy   <= 1'b0;
        end
    end
    assign uart_tx_busy = m_busy | hold_busy;

    // Byte collector and tx_data hold monitor.
    always @(negedge clk) begin
        if (!reset_n) begin
            act = 1'b0;
        end else if (tx_start) begin
            rx_q.push_back(tx_data);
            start_cnt++;
            act      = 1'b1;
            act_byte = tx_data;
            seen_hi  = 1'b0;
        end else if (act) begin
            if (tx_data !== act_byte) stab_err++;
            if (uart_tx_busy) seen_hi = 1'b1;
            else if (seen_hi) act = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef SUM_ECHO_OPERANDS_EN
    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction
`endif

    task automatic build_exp(input int a, input int b);
        int s;
        s = a + b;
        exp_q.delete();
`ifdef SUM_ECHO_OPERANDS_EN
        exp_q.push_back(hex_char(a));
        exp_q.push_back(8'h2B);
        exp_q.push_back(hex_char(b));
        exp_q.push_back(8'h3D);
`endif
        exp_q.push_back(8'(48 + s / 10));
        exp_q.push_back(8'(48 + s % 10));
        if (TB_CRLF != 0) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic press(input bit do_a, input bit do_b, input logic [3:0] v);
        data_input = v;
        if (do_a) save_a_n = 1'b0;
        if (do_b) save_b_n = 1'b0;
        ticks(6);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        ticks(3);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && seq_busy; i++) tick();
        check({tag, "_idle"}, 32'(seq_busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int a, input int b);
        logic [31:0] obs;
        build_exp(a, b);
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end
        check({tag, "_sum"}, 32'(sum_out), 32'(a + b));
        check({tag, "_flags"}, {30'd0, a_valid, b_valid}, 32'd0);
        check({tag, "_stable"}, 32'(stab_err), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int a, input int b);
        rx_q.delete();
        press(1'b1, 1'b0, 4'(a));
        check({tag, "_a_valid"}, {30'd0, a_valid, b_valid}, 32'd2);
        press(1'b0, 1'b1, 4'(b));
        wait_idle(tag);
        check_frame(tag, a, b);
    endtask

    initial begin
        int a;
        int b;
        int n0;
        int hold_starts;
        int hold_changes;
        logic [7:0] snap;

        checks     = 0;
        errors     = 0;
        start_cnt  = 0;
        stab_err   = 0;
        act        = 1'b0;
        seen_hi    = 1'b0;
        act_byte   = 8'h00;
        hold_busy  = 1'b0;
        busy_lo    = 2;
        busy_hi    = 6;
        save_a_n   = 1'b1;
        save_b_n   = 1'b1;
        data_input = 4'd0;
        reset_n    = 1'b0;
        ticks(3);
        check("reset_outputs", {18'd0, tx_start, tx_data, sum_out, a_valid, b_valid, seq_busy}, 32'd0);
        reset_n = 1'b1;
        ticks(2);

        run_frame("f7p9", 7, 9);
        run_frame("f15p15", 15, 15);
        run_frame("f0p0", 0, 0);

`ifdef SUM_ECHO_OPERANDS_EN
        run_frame("echo_a_p3", 10, 3);
`endif

        // Both strobes together load the same value.
        rx_q.delete();
        press(1'b1, 1'b1, 4'd6);
        wait_idle("both");
        check_frame("both", 6, 6);

        // UART stays busy while the sequencer waits in LOAD.
        a = int'($urandom_range(15, 0));
        b = int'($urandom_range(15, 0));
        hold_busy = 1'b1;
        rx_q.delete();
        press(1'b1, 1'b0, 4'(a));
        press(1'b0, 1'b1, 4'(b));
        for (int i = 0; i < 100 && !seq_busy; i++) tick();
        ticks(2);
        snap = tx_data;
        build_exp(a, b);
        check("hold_first_byte", 32'(snap), 32'(exp_q[0]));
        hold_starts  = 0;
        hold_changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) hold_starts++;
            if (tx_data !== snap) hold_changes++;
        end
        check("hold_no_start", 32'(hold_starts), 32'd0);
        check("hold_data_stable", 32'(hold_changes), 32'd0);
        hold_busy = 1'b0;
        wait_idle("hold");
        check_frame("hold", a, b);

        // A press during the second byte must be ignored.
        busy_lo = 10;
        busy_hi = 12;
        a = int'($urandom_range(15, 5));
        b = int'($urandom_range(15, 0));
        rx_q.delete();
        press(1'b1, 1'b0, 4'(a));
        press(1'b0, 1'b1, 4'(b));
        for (int i = 0; i < 200 && rx_q.size() < 2; i++) tick();
        press(1'b1, 1'b0, 4'd4);
        wait_idle("ign");
        check_frame("ign", a, b);
        check("ign_op_a", 32'(dut.op_a), 32'(a));

        // Reset while the second byte is shifting out.
        busy_lo = 6;
        busy_hi = 8;
        rx_q.delete();
        press(1'b1, 1'b0, 4'(int'($urandom_range(15, 0))));
        press(1'b0, 1'b1, 4'(int'($urandom_range(15, 0))));
        for (int i = 0; i < 200 && rx_q.size() < 2; i++) tick();
        for (int i = 0; i < 20 && !uart_tx_busy; i++) tick();
        tick();
        check("mid_second_byte", 32'(rx_q.size()), 32'd2);
        reset_n = 1'b0;
        #1;
        check("mid_reset_async", {18'd0, tx_start, tx_data, sum_out, a_valid, b_valid, seq_busy}, 32'd0);
        tick();
        check("mid_reset_held", {18'd0, tx_start, tx_data, sum_out, a_valid, b_valid, seq_busy}, 32'd0);
        reset_n = 1'b1;
        n0 = start_cnt;
        ticks(40);
        check("mid_no_resume", 32'(start_cnt - n0), 32'd0);
        check("mid_idle", {30'd0, seq_busy, a_valid | b_valid}, 32'd0);

        // Randomized frames against the reference model.
        for (int k = 0; k < 6; k++) begin
            busy_lo = int'($urandom_range(4, 2));
            busy_hi = busy_lo + int'($urandom_range(5, 0));
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            run_frame($sformatf("rnd%0d", k), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
